// File: rtl/eth_mac_pkg.sv
// Shared Ethernet MAC definitions: receive FSM states, preamble/SFD bytes, CRC seed.
package eth_mac_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StDiscard
  } rx_state_e;

  localparam logic [7:0]  ETH_PRE  = 8'h55;
  localparam logic [7:0]  ETH_SFD  = 8'hD5;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

endpackage

// File: rtl/ve_lfsr.sv
// Combinational LFSR step: advances state_in by DATA_WIDTH input bits.
// REVERSE=1 shifts LSB-first with the bit-reversed polynomial (Ethernet CRC-32).
// Ports: data_in - bits to fold in; state_in - current state; state_out - next state.
module ve_lfsr #(
  parameter int unsigned           LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h04c11db7,
  parameter bit                    REVERSE    = 1'b1,
  parameter int unsigned           DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  logic [LFSR_WIDTH-1:0] poly_rev;

  always_comb begin
    poly_rev = '0;
    for (int i = 0; i < int'(LFSR_WIDTH); i++) begin
      poly_rev[i] = LFSR_POLY[LFSR_WIDTH-1-i];
    end
  end

  always_comb begin
    logic [LFSR_WIDTH-1:0] s;
    logic                  fb;
    s  = state_in;
    fb = 1'b0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (REVERSE) begin
        fb = s[0] ^ data_in[i];
        s  = s >> 1;
        if (fb) s = s ^ poly_rev;
      end else begin
        fb = s[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
        s  = s << 1;
        if (fb) s = s ^ LFSR_POLY;
      end
    end
    state_out = s;
  end

endmodule

// File: rtl/gmii_axis_rx.sv
// GMII/MII receive framer: finds preamble+SFD, strips preamble, SFD and FCS,
// checks CRC-32 and emits the payload on an AXI4-Stream without backpressure.
// Optional feature macro: GMII_RX_PTP_TS_EN (adds ptp_ts input and SFD timestamp in tuser).
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   gmii_rxd/rx_dv/rx_er         - PHY receive data (MII nibble on [3:0])
//   m_axis_tdata/tvalid/tlast    - payload stream
//   m_axis_tuser                 - [0] bad frame, [USER_WIDTH-1:1] SFD timestamp (macro)
//   ptp_ts                       - current time (macro only)
//   clk_enable, mii_select       - cycle qualifier, nibble mode select
//   start_packet                 - pulse on SFD
//   error_bad_frame, error_bad_fcs - pulses for rx_er/runt and CRC mismatch
module gmii_axis_rx
  import eth_mac_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
`ifdef GMII_RX_PTP_TS_EN
  parameter int PTP_TS_WIDTH = 96,
  parameter int USER_WIDTH   = 1 + PTP_TS_WIDTH
`else
  parameter int USER_WIDTH   = 1
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   gmii_rxd,
  input  logic                    gmii_rx_dv,
  input  logic                    gmii_rx_er,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
`ifdef GMII_RX_PTP_TS_EN
  input  logic [PTP_TS_WIDTH-1:0] ptp_ts,
`endif
  input  logic                    clk_enable,
  input  logic                    mii_select,
  output logic                    start_packet,
  output logic                    error_bad_frame,
  output logic                    error_bad_fcs
);

  if (DATA_WIDTH != 8) begin : g_width_check
    $error("gmii_axis_rx: DATA_WIDTH must be 8");
  end

  rx_state_e   state_q;
  logic [7:0]  rxd_q;
  logic        dv_q, er_q;
  logic [3:0]  nib_q;
  logic        phase_q;
  logic [7:0]  dl_q [5];
  logic [2:0]  cnt_q;
  logic        er_seen_q;
  logic [31:0] crc_q, crc_next;
  logic [7:0]  byte_val;
  logic        fcs_bad;
`ifdef GMII_RX_PTP_TS_EN
  logic [PTP_TS_WIDTH-1:0] ts_q;
`endif

  // In MII mode the byte is the held low nibble plus the current high nibble.
  assign byte_val = mii_select ? {rxd_q[3:0], nib_q} : rxd_q;

  // FCS occupies r0..r3 (r3 first on the wire) and equals the inverted CRC state.
  assign fcs_bad = {dl_q[0], dl_q[1], dl_q[2], dl_q[3]} != ~crc_next;

  ve_lfsr #(
    .LFSR_WIDTH (32),
    .LFSR_POLY  (32'h04c11db7),
    .REVERSE    (1'b1),
    .DATA_WIDTH (8)
  ) u_crc (
    .data_in   (dl_q[4]),
    .state_in  (crc_q),
    .state_out (crc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      rxd_q           <= '0;
      dv_q            <= 1'b0;
      er_q            <= 1'b0;
      nib_q           <= '0;
      phase_q         <= 1'b0;
      for (int i = 0; i < 5; i++) dl_q[i] <= '0;
      cnt_q           <= '0;
      er_seen_q       <= 1'b0;
      crc_q           <= CRC_INIT;
      m_axis_tdata    <= '0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= '0;
      start_packet    <= 1'b0;
      error_bad_frame <= 1'b0;
      error_bad_fcs   <= 1'b0;
`ifdef GMII_RX_PTP_TS_EN
      ts_q            <= '0;
`endif
    end else begin
      // Strobes default low, which also forces them low on disabled cycles.
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      start_packet    <= 1'b0;
      error_bad_frame <= 1'b0;
      error_bad_fcs   <= 1'b0;
      if (clk_enable) begin
        rxd_q <= gmii_rxd;
        dv_q  <= gmii_rx_dv;
        er_q  <= gmii_rx_er;
        unique case (state_q)
          StIdle: begin
            er_seen_q <= 1'b0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            if (!dv_q) begin
              nib_q <= '0;
            end else if (mii_select) begin
              // Nibble alignment: an SFD high nibble right after a preamble nibble.
              if (rxd_q[3:0] == ETH_SFD[7:4] && nib_q == ETH_PRE[3:0]) begin
                state_q      <= StPayload;
                crc_q        <= CRC_INIT;
                start_packet <= 1'b1;
`ifdef GMII_RX_PTP_TS_EN
                ts_q         <= ptp_ts;
`endif
              end else if (rxd_q[3:0] == ETH_PRE[3:0]) begin
                nib_q <= rxd_q[3:0];
              end else begin
                state_q <= StDiscard;
              end
            end else if (rxd_q == ETH_SFD) begin
              state_q      <= StPayload;
              crc_q        <= CRC_INIT;
              start_packet <= 1'b1;
`ifdef GMII_RX_PTP_TS_EN
              ts_q         <= ptp_ts;
`endif
            end else if (rxd_q != ETH_PRE) begin
              state_q <= StDiscard;
            end
          end
          StPayload: begin
            if (er_q) er_seen_q <= 1'b1;
            if (!dv_q) begin
              state_q <= StIdle;
              phase_q <= 1'b0;
              nib_q   <= '0;
              if (cnt_q == 3'd5) begin
                m_axis_tvalid   <= 1'b1;
                m_axis_tlast    <= 1'b1;
                m_axis_tdata    <= dl_q[4];
                m_axis_tuser[0] <= er_seen_q | fcs_bad;
                crc_q           <= crc_next;
                error_bad_fcs   <= fcs_bad;
                error_bad_frame <= er_seen_q;
              end else begin
                error_bad_frame <= 1'b1;
              end
            end else if (mii_select && !phase_q) begin
              nib_q   <= rxd_q[3:0];
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              dl_q[0] <= byte_val;
              for (int i = 1; i < 5; i++) dl_q[i] <= dl_q[i-1];
              if (cnt_q == 3'd5) begin
                m_axis_tvalid   <= 1'b1;
                m_axis_tdata    <= dl_q[4];
                m_axis_tuser[0] <= 1'b0;
`ifdef GMII_RX_PTP_TS_EN
                m_axis_tuser[USER_WIDTH-1:1] <= ts_q;
`endif
                crc_q           <= crc_next;
              end else begin
                cnt_q <= cnt_q + 3'd1;
              end
            end
          end
          StDiscard: begin
            if (!dv_q) begin
              state_q <= StIdle;
              nib_q   <= '0;
              phase_q <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
